// File: rtl/countdown_timer_if.sv
// Control and status bundle for countdown_timer.
// The master side drives the commands and preset; the slave side (the timer)
// returns the count and status flags.
interface countdown_timer_if #(
  parameter int WIDTH = 4
);
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             start;
  logic             stop;
  logic             en;
  logic [WIDTH-1:0] count;
  logic             busy;
  logic             done;
  logic             tc;

  modport master (
    output load, load_val, start, stop, en,
    input  count, busy, done, tc
  );

  modport slave (
    input  load, load_val, start, stop, en,
    output count, busy, done, tc
  );
endinterface

// File: rtl/countdown_timer.sv
// Loadable down-counter with start/stop/enable control and a one-cycle
// terminal-count pulse.
// Build option: COUNTDOWN_TIMER_AUTO_RELOAD_EN. When it is defined, reaching
// terminal count reloads the counter from the reload register and keeps
// running, so DONE is never entered. When it is undefined, the timer is
// one-shot and parks in DONE.
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | stopped; count holds a preset or a paused value
// RUN    | counting down on each edge with en=1
// DONE   | one-shot finished; count is 0 until load or restart
module countdown_timer #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  countdown_timer_if.slave   bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] ZERO = '0;
  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

  state_t           r_state;
  logic [WIDTH-1:0] r_count;
  logic [WIDTH-1:0] r_reload;
  logic             r_tc;

  // State, count, reload register and tc pulse; priority is
  // rst > load > stop > start > en.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_count  <= ZERO;
      r_reload <= ZERO;
      r_tc     <= 1'b0;
    end else begin
      r_tc <= 1'b0;
      if (bus.load) begin
        r_count  <= bus.load_val;
        r_reload <= bus.load_val;
        r_state  <= S_IDLE;
      end else begin
        case (r_state)
          S_IDLE: begin
            // A zero count has nothing to time, so start is ignored.
            if (bus.start && (r_count != ZERO)) begin
              r_state <= S_RUN;
            end
          end
          S_RUN: begin
            if (bus.stop) begin
              r_state <= S_IDLE;
            end else if (bus.en) begin
              if (r_count == ONE) begin
                r_tc <= 1'b1;
`ifdef COUNTDOWN_TIMER_AUTO_RELOAD_EN
                r_count <= r_reload;
`else
                r_count <= ZERO;
                r_state <= S_DONE;
`endif
              end else if (r_count != ZERO) begin
                // Guard against zero keeps the count from ever wrapping.
                r_count <= r_count - ONE;
              end
            end
          end
          S_DONE: begin
            if (bus.start && (r_reload != ZERO)) begin
              r_count <= r_reload;
              r_state <= S_RUN;
            end
          end
          default: begin
            r_state <= S_IDLE;
          end
        endcase
      end
    end
  end

  // Status flags come straight from the state register.
  always_comb begin
    bus.busy = (r_state == S_RUN);
    bus.done = (r_state == S_DONE);
  end

  assign bus.count = r_count;
  assign bus.tc    = r_tc;

endmodule

// File: tb/tb_countdown_timer.sv
module tb_countdown_timer;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  countdown_timer_if #(.WIDTH(4)) bus ();

  countdown_timer #(.WIDTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle; inputs are changed and outputs are
  // sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    rst          = 1'b0;
    bus.load     = 1'b0;
    bus.load_val = 4'd0;
    bus.start    = 1'b0;
    bus.stop     = 1'b0;
    bus.en       = 1'b0;
  endtask

  task automatic do_load(input logic [3:0] v);
    clear_inputs();
    bus.load     = 1'b1;
    bus.load_val = v;
    step();
    bus.load = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst          = 1'b1;
    bus.load     = 1'b1;
    bus.load_val = 4'd9;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if ({bus.count, bus.busy, bus.done, bus.tc} !== 7'b0) begin
        errors++;
        $display("FAIL reset[%0d]: count=%0d busy=%b done=%b tc=%b, expected 0 0 0 0",
                 i, bus.count, bus.busy, bus.done, bus.tc);
      end
    end
    clear_inputs();
    step();
    checks++;
    if ({bus.count, bus.busy, bus.done} !== 6'b0) begin
      errors++;
      $display("FAIL reset_release: count=%0d busy=%b done=%b, expected 0 0 0",
               bus.count, bus.busy, bus.done);
    end
  endtask

`ifndef COUNTDOWN_TIMER_AUTO_RELOAD_EN
  task automatic test_one_shot();
    logic [3:0] exp_cnt  [7] = '{4'd5, 4'd4, 4'd3, 4'd2, 4'd1, 4'd0, 4'd0};
    logic       exp_tc   [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic       exp_busy [7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    logic       exp_done [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    do_load(4'd5);
    bus.start = 1'b1;
    bus.en    = 1'b1;
    for (int i = 0; i < 7; i++) begin
      step();
      bus.start = 1'b0;
      checks++;
      if (bus.count !== exp_cnt[i] || bus.tc !== exp_tc[i] ||
          bus.busy !== exp_busy[i] || bus.done !== exp_done[i]) begin
        errors++;
        $display("FAIL one_shot[%0d]: count=%0d tc=%b busy=%b done=%b, expected %0d %b %b %b",
                 i, bus.count, bus.tc, bus.busy, bus.done,
                 exp_cnt[i], exp_tc[i], exp_busy[i], exp_done[i]);
      end
    end
    // stop in DONE has no effect
    bus.stop = 1'b1;
    step();
    bus.stop = 1'b0;
    checks++;
    if (bus.done !== 1'b1 || bus.count !== 4'd0) begin
      errors++;
      $display("FAIL done_stop: done=%b count=%0d, expected 1 0", bus.done, bus.count);
    end
  endtask
`endif

  task automatic test_pause_stop();
    // Per edge: start, en, stop driven; then expected count and busy.
    logic       v_start [9] = '{1, 0, 0, 0, 0, 0, 1, 0, 0};
    logic       v_en    [9] = '{1, 1, 0, 1, 0, 0, 1, 1, 1};
    logic       v_stop  [9] = '{0, 0, 0, 0, 1, 0, 0, 0, 0};
    logic [3:0] e_cnt   [9] = '{6, 5, 5, 4, 4, 4, 4, 3, 2};
    logic       e_busy  [9] = '{1, 1, 1, 1, 0, 0, 1, 1, 1};
    do_load(4'd6);
    for (int i = 0; i < 9; i++) begin
      bus.start = v_start[i];
      bus.en    = v_en[i];
      bus.stop  = v_stop[i];
      step();
      checks++;
      if (bus.count !== e_cnt[i] || bus.busy !== e_busy[i] || bus.tc !== 1'b0) begin
        errors++;
        $display("FAIL pause_stop[%0d]: count=%0d busy=%b tc=%b, expected %0d %b 0",
                 i, bus.count, bus.busy, bus.tc, e_cnt[i], e_busy[i]);
      end
    end
    clear_inputs();
  endtask

  task automatic test_priority();
    do_load(4'd5);
    bus.start = 1'b1;
    bus.en    = 1'b1;
    step();
    bus.start = 1'b0;
    step();
    step();
    checks++;
    if (bus.count !== 4'd3 || bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL prio_setup: count=%0d busy=%b, expected 3 1", bus.count, bus.busy);
    end
    bus.load     = 1'b1;
    bus.load_val = 4'd12;
    bus.stop     = 1'b1;
    bus.start    = 1'b1;
    step();
    checks++;
    if (bus.count !== 4'd12 || bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.tc !== 1'b0) begin
      errors++;
      $display("FAIL prio_load: count=%0d busy=%b done=%b tc=%b, expected 12 0 0 0",
               bus.count, bus.busy, bus.done, bus.tc);
    end
    clear_inputs();
    bus.en = 1'b1;
    step();
    checks++;
    if (bus.count !== 4'd12 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL prio_idle_hold: count=%0d busy=%b, expected 12 0", bus.count, bus.busy);
    end
    clear_inputs();
  endtask

  task automatic test_edge_cases();
    do_load(4'd0);
    bus.start = 1'b1;
    bus.en    = 1'b1;
    step();
    checks++;
    if (bus.count !== 4'd0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      errors++;
      $display("FAIL zero_start: count=%0d busy=%b done=%b, expected 0 0 0",
               bus.count, bus.busy, bus.done);
    end
    do_load(4'd15);
    bus.start = 1'b1;
    bus.en    = 1'b1;
    step();
    bus.start = 1'b0;
`ifndef COUNTDOWN_TIMER_AUTO_RELOAD_EN
    for (int i = 0; i < 15; i++) step();
    checks++;
    if (bus.count !== 4'd0 || bus.done !== 1'b1 || bus.tc !== 1'b1) begin
      errors++;
      $display("FAIL run15_done: count=%0d done=%b tc=%b, expected 0 1 1",
               bus.count, bus.done, bus.tc);
    end
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    checks++;
    if (bus.count !== 4'd15 || bus.busy !== 1'b1 || bus.done !== 1'b0) begin
      errors++;
      $display("FAIL done_restart: count=%0d busy=%b done=%b, expected 15 1 0",
               bus.count, bus.busy, bus.done);
    end
`endif
    for (int i = 0; i < 8; i++) step();
    checks++;
    if (bus.count !== 4'd7 || bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL reach7: count=%0d busy=%b, expected 7 1", bus.count, bus.busy);
    end
    rst          = 1'b1;
    bus.load     = 1'b1;
    bus.load_val = 4'd9;
    bus.start    = 1'b1;
    bus.stop     = 1'b1;
    step();
    checks++;
    if (bus.count !== 4'd0 || bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.tc !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid: count=%0d busy=%b done=%b tc=%b, expected 0 0 0 0",
               bus.count, bus.busy, bus.done, bus.tc);
    end
    clear_inputs();
    step();
  endtask

`ifdef COUNTDOWN_TIMER_AUTO_RELOAD_EN
  task automatic test_auto_reload();
    logic [3:0] e_cnt [9] = '{2, 1, 3, 2, 1, 3, 2, 1, 3};
    logic       e_tc  [9] = '{0, 0, 1, 0, 0, 1, 0, 0, 1};
    do_load(4'd3);
    bus.start = 1'b1;
    bus.en    = 1'b1;
    step();
    bus.start = 1'b0;
    checks++;
    if (bus.count !== 4'd3 || bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL auto_start: count=%0d busy=%b, expected 3 1", bus.count, bus.busy);
    end
    for (int i = 0; i < 9; i++) begin
      step();
      checks++;
      if (bus.count !== e_cnt[i] || bus.tc !== e_tc[i] ||
          bus.done !== 1'b0 || bus.busy !== 1'b1) begin
        errors++;
        $display("FAIL auto[%0d]: count=%0d tc=%b done=%b busy=%b, expected %0d %b 0 1",
                 i, bus.count, bus.tc, bus.done, bus.busy, e_cnt[i], e_tc[i]);
      end
    end
    clear_inputs();
  endtask
`endif

  initial begin
    checks = 0;
    errors = 0;
    clear_inputs();
    test_reset();
`ifndef COUNTDOWN_TIMER_AUTO_RELOAD_EN
    test_one_shot();
`endif
    test_pause_stop();
    test_priority();
    test_edge_cases();
`ifdef COUNTDOWN_TIMER_AUTO_RELOAD_EN
    test_auto_reload();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
